// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control sequencer.
// Opcodes, IR field positions, FSM states and opcode classes.
package cpu_pkg;

  localparam int OPC_W = 5;

  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_SHRA = 5'b01010;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b10000;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [2:0] {
    T0, T1, T2, T3, T4, T5, T6, HALTED
  } state_t;

  typedef enum logic [2:0] {
    C_BIN, C_MD, C_UN, C_NOP, C_HALT, C_BAD
  } op_class_t;

  function automatic op_class_t classify(
    input logic [OPC_W-1:0] op
  );
    op_class_t c;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ROR, OP_ROL, OP_SHR, OP_SHRA,
      OP_SHL:          c = C_BIN;
      OP_DIV, OP_MUL:  c = C_MD;
      OP_NEG, OP_NOT:  c = C_UN;
      OP_NOP:          c = C_NOP;
      OP_HALT:         c = C_HALT;
      default:         c = C_BAD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_control_sequencer_if.sv
// Control bundle between the sequencer and the DataPath.
// master = sequencer side, slave = DataPath side.
interface alu_control_sequencer_if #(
  parameter int NUM_REGS = 16,
  parameter int OPC_W    = 5
);
  logic [31:0]         IR;
  logic                PCout, Zhighout, Zlowout, MDRout;
  logic                MARin, PCin, MDRin, IRin;
  logic                Yin, IncPC, Read;
  logic                ZHighIn, ZLowIn, HIin, LOin;
  logic [NUM_REGS-1:0] Rin, Rout;
  logic [OPC_W-1:0]    opcode;
  logic                run, illegal;

  modport master (
    input  IR,
    output PCout, Zhighout, Zlowout, MDRout,
    output MARin, PCin, MDRin, IRin,
    output Yin, IncPC, Read,
    output ZHighIn, ZLowIn, HIin, LOin,
    output Rin, Rout, opcode, run, illegal
  );

  modport slave (
    output IR,
    input  PCout, Zhighout, Zlowout, MDRout,
    input  MARin, PCin, MDRin, IRin,
    input  Yin, IncPC, Read,
    input  ZHighIn, ZLowIn, HIin, LOin,
    input  Rin, Rout, opcode, run, illegal
  );
endinterface

// File: rtl/reg_sel_decoder.sv
// 4-bit register index plus enable to one-hot select.
// All-zero output whenever the enable is low.
module reg_sel_decoder #(
  parameter int N = 16
) (
  input  logic [3:0]   idx,
  input  logic         en,
  output logic [N-1:0] onehot
);
  assign onehot = en ? (N'(1) << idx) : '0;
endmodule

// File: rtl/alu_control_sequencer.sv
// Hardwired fetch/execute sequencer for register ALU ops.
// Moore outputs from state and IR; clear forces all strobes low.
module alu_control_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int OPC_W    = 5
) (
  input logic                      clock,
  input logic                      clear,
  alu_control_sequencer_if.master  bus
);
  import cpu_pkg::*;

  state_t           state, nxt;
  logic [OPC_W-1:0] op_q;
  logic [3:0]       ra_q, rb_q, rc_q;
  logic [OPC_W-1:0] cur_op;
  logic [3:0]       cur_ra, cur_rb, cur_rc;
  op_class_t        cls;
  logic             rin_en, rout_en;
  logic [3:0]       rin_idx, rout_idx;
  logic [OPC_W-1:0] op_out;
  logic             unused_ir;

  assign unused_ir = ^bus.IR[RC_LO-1:0];

  // T3 decodes the live IR; later states use the copy taken in T3.
  assign cur_op = (state == T3) ? bus.IR[OP_HI:OP_LO] : op_q;
  assign cur_ra = (state == T3) ? bus.IR[RA_HI:RA_LO] : ra_q;
  assign cur_rb = (state == T3) ? bus.IR[RB_HI:RB_LO] : rb_q;
  assign cur_rc = (state == T3) ? bus.IR[RC_HI:RC_LO] : rc_q;
  assign cls    = classify(cur_op);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= T0;
    else       state <= nxt;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      op_q <= '0;
      ra_q <= '0;
      rb_q <= '0;
      rc_q <= '0;
    end else if (state == T3) begin
      op_q <= cur_op;
      ra_q <= cur_ra;
      rb_q <= cur_rb;
      rc_q <= cur_rc;
    end
  end

  always_comb begin
    nxt = T0;
    unique case (state)
      T0: nxt = T1;
      T1: nxt = T2;
      T2: nxt = T3;
      T3: begin
        unique case (cls)
          C_NOP, C_BAD: nxt = T0;
          C_HALT:       nxt = HALTED;
          default:      nxt = T4;
        endcase
      end
      T4:     nxt = (cls == C_UN) ? T0 : T5;
      T5:     nxt = (cls == C_MD) ? T6 : T0;
      T6:     nxt = T0;
      HALTED: nxt = HALTED;
      default: nxt = T0;
    endcase
  end

  always_comb begin
    bus.PCout    = 1'b0;
    bus.Zhighout = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.MDRout   = 1'b0;
    bus.MARin    = 1'b0;
    bus.PCin     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Read     = 1'b0;
    bus.ZHighIn  = 1'b0;
    bus.ZLowIn   = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    rin_en       = 1'b0;
    rout_en      = 1'b0;
    rin_idx      = cur_ra;
    rout_idx     = cur_rb;
    op_out       = '0;
    if (!clear) begin
      unique case (state)
        T0: begin
          bus.PCout = 1'b1;
          bus.MARin = 1'b1;
          bus.IncPC = 1'b1;
        end
        T1: begin
          bus.Read  = 1'b1;
          bus.MDRin = 1'b1;
        end
        T2: begin
          bus.MDRout = 1'b1;
          bus.IRin   = 1'b1;
        end
        T3: begin
          unique case (cls)
            C_BIN: begin
              rout_en  = 1'b1;
              rout_idx = cur_rc;
              bus.Yin  = 1'b1;
            end
            C_MD: begin
              rout_en  = 1'b1;
              rout_idx = cur_ra;
              bus.Yin  = 1'b1;
            end
            C_UN: begin
              rout_en    = 1'b1;
              op_out     = cur_op;
              bus.ZLowIn = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          unique case (cls)
            C_BIN: begin
              rout_en    = 1'b1;
              op_out     = cur_op;
              bus.ZLowIn = 1'b1;
            end
            C_MD: begin
              rout_en     = 1'b1;
              op_out      = cur_op;
              bus.ZLowIn  = 1'b1;
              bus.ZHighIn = 1'b1;
            end
            C_UN: begin
              bus.Zlowout = 1'b1;
              rin_en      = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          unique case (cls)
            C_BIN: begin
              bus.Zlowout = 1'b1;
              rin_en      = 1'b1;
            end
            C_MD: begin
              bus.Zlowout = 1'b1;
              bus.LOin    = 1'b1;
            end
            default: ;
          endcase
        end
        T6: begin
          bus.Zhighout = 1'b1;
          bus.HIin     = 1'b1;
        end
        HALTED: ;
        default: ;
      endcase
    end
  end

  assign bus.opcode  = op_out;
  assign bus.run     = (state != HALTED);
  assign bus.illegal = !clear && (state == T3)
                     && (cls == C_BAD);

  reg_sel_decoder #(.N(NUM_REGS)) u_rin (
    .idx    (rin_idx),
    .en     (rin_en),
    .onehot (bus.Rin)
  );

  reg_sel_decoder #(.N(NUM_REGS)) u_rout (
    .idx    (rout_idx),
    .en     (rout_en),
    .onehot (bus.Rout)
  );

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Randomized bench for alu_control_sequencer.
// Expected cycles come from a per-instruction table model.
module tb_alu_control_sequencer;

  typedef struct packed {
    logic        pcout, zhighout, zlowout, mdrout;
    logic        marin, pcin, mdrin, irin;
    logic        yin, incpc, read;
    logic        zhighin, zlowin, hiin, loin;
    logic [15:0] rin, rout;
    logic [4:0]  opcode;
    logic        run, illegal;
  } vec_t;

  logic clock = 1'b0;
  logic clear = 1'b1;
  int   checks = 0;
  int   failures = 0;
  vec_t q[$];
  logic mon_en = 1'b0;
  logic rin_seen = 1'b0;

  logic [4:0] legal_ops [0:13] = '{
    5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
    5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01111,
    5'b10000, 5'b10001, 5'b10010, 5'b11010
  };

  always #5 clock = ~clock;

  alu_control_sequencer_if #(.NUM_REGS(16), .OPC_W(5)) bus ();

  alu_control_sequencer #(.NUM_REGS(16), .OPC_W(5)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always @(bus.Rin) if (mon_en && bus.Rin != 16'h0) rin_seen = 1'b1;

  function automatic vec_t observe();
    vec_t v;
    v.pcout = bus.PCout;     v.zhighout = bus.Zhighout;
    v.zlowout = bus.Zlowout; v.mdrout = bus.MDRout;
    v.marin = bus.MARin;     v.pcin = bus.PCin;
    v.mdrin = bus.MDRin;     v.irin = bus.IRin;
    v.yin = bus.Yin;         v.incpc = bus.IncPC;
    v.read = bus.Read;       v.zhighin = bus.ZHighIn;
    v.zlowin = bus.ZLowIn;   v.hiin = bus.HIin;
    v.loin = bus.LOin;       v.rin = bus.Rin;
    v.rout = bus.Rout;       v.opcode = bus.opcode;
    v.run = bus.run;         v.illegal = bus.illegal;
    return v;
  endfunction

  function automatic vec_t idle();
    vec_t v = '0;
    v.run = 1'b1;
    return v;
  endfunction

  // One entry per clock of the instruction, starting at T0.
  function automatic void build(input logic [31:0] ir);
    logic [4:0] op = ir[31:27];
    int ra = int'(ir[26:23]);
    int rb = int'(ir[22:19]);
    int rc = int'(ir[18:15]);
    vec_t v;
    q.delete();
    v = idle(); v.pcout = 1; v.marin = 1; v.incpc = 1; q.push_back(v);
    v = idle(); v.read = 1; v.mdrin = 1; q.push_back(v);
    v = idle(); v.mdrout = 1; v.irin = 1; q.push_back(v);
    if (op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110,
                   5'b00111, 5'b01000, 5'b01001, 5'b01010,
                   5'b01011}) begin
      v = idle(); v.rout = 16'd1 << rc; v.yin = 1; q.push_back(v);
      v = idle(); v.rout = 16'd1 << rb; v.opcode = op;
      v.zlowin = 1; q.push_back(v);
      v = idle(); v.zlowout = 1; v.rin = 16'd1 << ra; q.push_back(v);
    end else if (op == 5'b01111 || op == 5'b10000) begin
      v = idle(); v.rout = 16'd1 << ra; v.yin = 1; q.push_back(v);
      v = idle(); v.rout = 16'd1 << rb; v.opcode = op;
      v.zlowin = 1; v.zhighin = 1; q.push_back(v);
      v = idle(); v.zlowout = 1; v.loin = 1; q.push_back(v);
      v = idle(); v.zhighout = 1; v.hiin = 1; q.push_back(v);
    end else if (op == 5'b10001 || op == 5'b10010) begin
      v = idle(); v.rout = 16'd1 << rb; v.opcode = op;
      v.zlowin = 1; q.push_back(v);
      v = idle(); v.zlowout = 1; v.rin = 16'd1 << ra; q.push_back(v);
    end else if (op == 5'b11010) begin
      q.push_back(idle());
    end else if (op == 5'b11011) begin
      q.push_back(idle());
      for (int i = 0; i < 20; i++) q.push_back(vec_t'(0));
    end else begin
      v = idle(); v.illegal = 1; q.push_back(v);
    end
  endfunction

  // Entered just after a negedge with the DUT in T0.
  task automatic run_instr(input logic [31:0] ir, input string name);
    vec_t obs;
    build(ir);
    bus.IR = ir;
    #1;
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) begin
        @(posedge clock);
        #1;
        if (i >= 4) bus.IR = $urandom;
        @(negedge clock);
        #1;
      end
      obs = observe();
      checks++;
      if (obs !== q[i]) begin
        failures++;
        $display("FAIL %s ir=%h cyc%0d got=%h exp=%h",
                 name, ir, i, obs, q[i]);
      end
    end
    @(negedge clock);
  endtask

  function automatic logic [31:0] rand_ir(input logic [4:0] op);
    logic [31:0] r = $urandom;
    return {op, r[26:0]};
  endfunction

  task automatic test_reset();
    vec_t obs;
    bus.IR = 32'h3A1B8000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      obs = observe();
      checks++;
      if (obs !== idle()) begin
        failures++;
        $display("FAIL reset got=%h exp=%h", obs, idle());
      end
    end
    @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic test_ror();
    run_instr(32'h3A1B8000, "ror");
    run_instr(32'hD0000000, "after_ror_nop");
  endtask

  task automatic test_mul();
    run_instr(32'h81180000, "mul");
    run_instr(rand_ir(5'b01111), "div");
  endtask

  task automatic test_not();
    run_instr(32'h92880000, "not");
    run_instr(rand_ir(5'b10001), "neg");
  endtask

  task automatic test_illegal();
    logic [4:0] bad [0:5] = '{5'b11111, 5'b00000, 5'b01100,
                             5'b10011, 5'b11000, 5'b11100};
    for (int i = 0; i < 6; i++) run_instr(rand_ir(bad[i]), "illegal");
    run_instr(32'h18000000, "add_r0_r0_r0");
  endtask

  task automatic test_random();
    logic [4:0] op;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) op = 5'($urandom_range(28, 31));
      else op = legal_ops[$urandom_range(0, 13)];
      run_instr(rand_ir(op), "random");
    end
  endtask

  task automatic test_clear_mid();
    vec_t obs;
    vec_t t0;
    t0 = idle(); t0.pcout = 1; t0.marin = 1; t0.incpc = 1;
    bus.IR = rand_ir(5'b00011);
    rin_seen = 1'b0;
    repeat (4) @(posedge clock);
    mon_en = 1'b1;
    #2 clear = 1'b1;
    #1 obs = observe();
    checks++;
    if (obs !== idle()) begin
      failures++;
      $display("FAIL clear_async got=%h exp=%h", obs, idle());
    end
    @(negedge clock);
    #1 obs = observe();
    checks++;
    if (obs !== idle()) begin
      failures++;
      $display("FAIL clear_hold got=%h exp=%h", obs, idle());
    end
    clear = 1'b0;
    #1 obs = observe();
    checks++;
    if (obs !== t0) begin
      failures++;
      $display("FAIL clear_release got=%h exp=%h", obs, t0);
    end
    run_instr(32'hD0000000, "post_clear_nop");
    mon_en = 1'b0;
    checks++;
    if (rin_seen !== 1'b0) begin
      failures++;
      $display("FAIL clear_no_rin got=%b exp=0", rin_seen);
    end
  endtask

  task automatic test_halt();
    vec_t obs;
    run_instr(32'hD8000000, "halt");
    #1 clear = 1'b1;
    #1 obs = observe();
    checks++;
    if (obs !== idle()) begin
      failures++;
      $display("FAIL halt_clear got=%h exp=%h", obs, idle());
    end
    @(negedge clock);
    clear = 1'b0;
    run_instr(32'h3A1B8000, "after_halt_ror");
  endtask

  initial begin
    bus.IR = '0;
    test_reset();
    test_ror();
    test_mul();
    test_not();
    test_illegal();
    test_random();
    test_clear_mid();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
